// File: rtl/id_ex_pipe_ctrl_pkg.sv
// Shared defaults and operand forward-select encodings for the ID/EX pipeline control slice.
package id_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned CTRL_W_DEF  = 16;
    localparam int unsigned NUM_FWD_DEF = 2;

    // Select encodings: register file, EX-stage register, then FWD_BASE+k for downstream stage k.
    localparam int unsigned FWD_RF   = 0;
    localparam int unsigned FWD_EX   = 1;
    localparam int unsigned FWD_BASE = 2;

    function automatic int unsigned sel_width(input int unsigned num_fwd);
        return $clog2(num_fwd + 2);
    endfunction

endpackage

// File: rtl/id_ex_pipe_ctrl_if.sv
// ID/EX boundary bundle: decoded-instruction input, bypass sources, and registered EX-side output.
interface id_ex_pipe_ctrl_if
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned CTRL_W  = CTRL_W_DEF,
    parameter int unsigned NUM_FWD = NUM_FWD_DEF,
    parameter int unsigned SEL_W   = sel_width(NUM_FWD)
) ();

    logic                   IN_VALID;
    logic                   IN_READY;
    logic [XLEN-1:0]        IN_PC;
    logic [XLEN-1:0]        IN_IMM;
    logic [XLEN-1:0]        IN_RDATA1;
    logic [XLEN-1:0]        IN_RDATA2;
    logic [4:0]             IN_RS1;
    logic [4:0]             IN_RS2;
    logic [4:0]             IN_RD;
    logic                   IN_USES_RS1;
    logic                   IN_USES_RS2;
    logic                   IN_WRITE_EN;
    logic                   IN_MEM_READ;
    logic [CTRL_W-1:0]      IN_CTRL;

    logic                   WB_WE;
    logic [4:0]             WB_RD;
    logic [XLEN-1:0]        WB_DATA;

    logic [NUM_FWD-1:0]     FWD_WE;
    logic [5*NUM_FWD-1:0]   FWD_RD;

    logic                   FLUSH;
    logic                   OUT_READY;

    logic                   OUT_VALID;
    logic [XLEN-1:0]        OUT_PC;
    logic [XLEN-1:0]        OUT_IMM;
    logic [XLEN-1:0]        OUT_RDATA1;
    logic [XLEN-1:0]        OUT_RDATA2;
    logic [4:0]             OUT_RD;
    logic [CTRL_W-1:0]      OUT_CTRL;
    logic                   OUT_WRITE_EN;
    logic                   OUT_MEM_READ;
    logic [SEL_W-1:0]       OUT_FWD_SEL1;
    logic [SEL_W-1:0]       OUT_FWD_SEL2;
    logic [31:0]            STALL_CNT;

    modport master (
        output IN_VALID, IN_PC, IN_IMM, IN_RDATA1, IN_RDATA2, IN_RS1, IN_RS2, IN_RD,
               IN_USES_RS1, IN_USES_RS2, IN_WRITE_EN, IN_MEM_READ, IN_CTRL,
               WB_WE, WB_RD, WB_DATA, FWD_WE, FWD_RD, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_PC, OUT_IMM, OUT_RDATA1, OUT_RDATA2, OUT_RD,
               OUT_CTRL, OUT_WRITE_EN, OUT_MEM_READ, OUT_FWD_SEL1, OUT_FWD_SEL2, STALL_CNT
    );

    modport slave (
        input  IN_VALID, IN_PC, IN_IMM, IN_RDATA1, IN_RDATA2, IN_RS1, IN_RS2, IN_RD,
               IN_USES_RS1, IN_USES_RS2, IN_WRITE_EN, IN_MEM_READ, IN_CTRL,
               WB_WE, WB_RD, WB_DATA, FWD_WE, FWD_RD, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, OUT_PC, OUT_IMM, OUT_RDATA1, OUT_RDATA2, OUT_RD,
               OUT_CTRL, OUT_WRITE_EN, OUT_MEM_READ, OUT_FWD_SEL1, OUT_FWD_SEL2, STALL_CNT
    );

endinterface

// File: rtl/id_ex_pipe_ctrl_fwd_select.sv
// Per-operand bypass: picks the forward-select code and applies same-cycle writeback substitution.
module fwd_select
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NUM_FWD = NUM_FWD_DEF,
    parameter int unsigned SEL_W   = sel_width(NUM_FWD)
) (
    input  logic [4:0]           rs,
    input  logic                 uses,
    input  logic                 cur_valid,
    input  logic                 cur_we,
    input  logic [4:0]           cur_rd,
    input  logic [NUM_FWD-1:0]   fwd_we,
    input  logic [5*NUM_FWD-1:0] fwd_rd,
    input  logic                 wb_we,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [XLEN-1:0]      rdata,
    output logic [SEL_W-1:0]     sel,
    output logic [XLEN-1:0]      data
);

    logic active;
    logic found;

    assign active = uses && (rs != 5'd0);

    // Nearest producer wins: EX register first, then downstream stages in index order.
    always_comb begin
        sel   = SEL_W'(FWD_RF);
        found = 1'b0;
        if (active) begin
            if (cur_valid && cur_we && (cur_rd == rs)) begin
                sel   = SEL_W'(FWD_EX);
                found = 1'b1;
            end
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (!found && fwd_we[k] && (fwd_rd[5*k +: 5] == rs)) begin
                    sel   = SEL_W'(FWD_BASE + k);
                    found = 1'b1;
                end
            end
        end
    end

    assign data = (active && wb_we && (wb_rd == rs)) ? wb_data : rdata;

endmodule

// File: rtl/id_ex_pipe_ctrl.sv
// ID/EX pipeline register with load-use bubble insertion, flush, and operand bypass selection.
module id_ex_pipe_ctrl
    import id_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned CTRL_W  = CTRL_W_DEF,
    parameter int unsigned NUM_FWD = NUM_FWD_DEF,
    parameter int unsigned SEL_W   = sel_width(NUM_FWD)
) (
    input  logic               CLK,
    input  logic               RST,
    id_ex_pipe_ctrl_if.slave   bus
);

    logic                 out_valid;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_imm;
    logic [XLEN-1:0]      out_rdata1;
    logic [XLEN-1:0]      out_rdata2;
    logic [4:0]           out_rd;
    logic [CTRL_W-1:0]    out_ctrl;
    logic                 out_write_en;
    logic                 out_mem_read;
    logic [SEL_W-1:0]     out_fwd_sel1;
    logic [SEL_W-1:0]     out_fwd_sel2;
    logic [31:0]          stall_cnt;

    logic                 adv;
    logic                 haz;
    logic                 rs1_hit;
    logic                 rs2_hit;
    logic [SEL_W-1:0]     nxt_sel1;
    logic [SEL_W-1:0]     nxt_sel2;
    logic [XLEN-1:0]      nxt_rdata1;
    logic [XLEN-1:0]      nxt_rdata2;

    assign adv     = bus.OUT_READY || !out_valid;
    assign rs1_hit = bus.IN_USES_RS1 && (bus.IN_RS1 == out_rd);
    assign rs2_hit = bus.IN_USES_RS2 && (bus.IN_RS2 == out_rd);
    assign haz     = bus.IN_VALID && out_valid && out_mem_read && (out_rd != 5'd0)
                     && (rs1_hit || rs2_hit);

    assign bus.IN_READY = bus.FLUSH || (adv && !haz);

    fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
    ) u_fwd1 (
        .rs        (bus.IN_RS1),
        .uses      (bus.IN_USES_RS1),
        .cur_valid (out_valid),
        .cur_we    (out_write_en),
        .cur_rd    (out_rd),
        .fwd_we    (bus.FWD_WE),
        .fwd_rd    (bus.FWD_RD),
        .wb_we     (bus.WB_WE),
        .wb_rd     (bus.WB_RD),
        .wb_data   (bus.WB_DATA),
        .rdata     (bus.IN_RDATA1),
        .sel       (nxt_sel1),
        .data      (nxt_rdata1)
    );

    fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .SEL_W   (SEL_W)
    ) u_fwd2 (
        .rs        (bus.IN_RS2),
        .uses      (bus.IN_USES_RS2),
        .cur_valid (out_valid),
        .cur_we    (out_write_en),
        .cur_rd    (out_rd),
        .fwd_we    (bus.FWD_WE),
        .fwd_rd    (bus.FWD_RD),
        .wb_we     (bus.WB_WE),
        .wb_rd     (bus.WB_RD),
        .wb_data   (bus.WB_DATA),
        .rdata     (bus.IN_RDATA2),
        .sel       (nxt_sel2),
        .data      (nxt_rdata2)
    );

    // Flush beats everything (even a held output); a bubble leaves the datapath fields untouched.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_rdata1   <= '0;
            out_rdata2   <= '0;
            out_rd       <= '0;
            out_ctrl     <= '0;
            out_write_en <= 1'b0;
            out_mem_read <= 1'b0;
            out_fwd_sel1 <= '0;
            out_fwd_sel2 <= '0;
            stall_cnt    <= '0;
        end else if (bus.FLUSH) begin
            out_valid    <= 1'b0;
            out_write_en <= 1'b0;
            out_mem_read <= 1'b0;
            out_fwd_sel1 <= '0;
            out_fwd_sel2 <= '0;
        end else if (adv && haz) begin
            out_valid    <= 1'b0;
            out_write_en <= 1'b0;
            out_mem_read <= 1'b0;
            out_fwd_sel1 <= '0;
            out_fwd_sel2 <= '0;
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end else if (adv) begin
            out_valid    <= bus.IN_VALID;
            out_pc       <= bus.IN_PC;
            out_imm      <= bus.IN_IMM;
            out_rdata1   <= nxt_rdata1;
            out_rdata2   <= nxt_rdata2;
            out_rd       <= bus.IN_RD;
            out_ctrl     <= bus.IN_CTRL;
            out_write_en <= bus.IN_WRITE_EN;
            out_mem_read <= bus.IN_MEM_READ;
            out_fwd_sel1 <= nxt_sel1;
            out_fwd_sel2 <= nxt_sel2;
        end
    end

    assign bus.OUT_VALID    = out_valid;
    assign bus.OUT_PC       = out_pc;
    assign bus.OUT_IMM      = out_imm;
    assign bus.OUT_RDATA1   = out_rdata1;
    assign bus.OUT_RDATA2   = out_rdata2;
    assign bus.OUT_RD       = out_rd;
    assign bus.OUT_CTRL     = out_ctrl;
    assign bus.OUT_WRITE_EN = out_write_en;
    assign bus.OUT_MEM_READ = out_mem_read;
    assign bus.OUT_FWD_SEL1 = out_fwd_sel1;
    assign bus.OUT_FWD_SEL2 = out_fwd_sel2;
    assign bus.STALL_CNT    = stall_cnt;

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Scenario bench for id_ex_pipe_ctrl: queued expected bundles checked one cycle after acceptance.
module tb_id_ex_pipe_ctrl;
    import id_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic [15:0] ctrl;
        logic        we;
        logic        mr;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    exp_t last;

    id_ex_pipe_ctrl_if #(.XLEN(32), .CTRL_W(16), .NUM_FWD(2), .SEL_W(2)) bus ();

    id_ex_pipe_ctrl #(.XLEN(32), .CTRL_W(16), .NUM_FWD(2), .SEL_W(2)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    function automatic exp_t obs();
        exp_t o;
        o.valid = bus.OUT_VALID;    o.pc   = bus.OUT_PC;      o.imm = bus.OUT_IMM;
        o.rd1   = bus.OUT_RDATA1;   o.rd2  = bus.OUT_RDATA2;  o.rd  = bus.OUT_RD;
        o.ctrl  = bus.OUT_CTRL;     o.we   = bus.OUT_WRITE_EN; o.mr = bus.OUT_MEM_READ;
        o.sel1  = bus.OUT_FWD_SEL1; o.sel2 = bus.OUT_FWD_SEL2;
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                                    input logic [4:0] rd, input logic we, input logic mr,
                                    input logic [1:0] s1, input logic [1:0] s2);
        exp_t e;
        e.valid = 1'b1; e.pc = pc; e.imm = pc ^ 32'hA5A5_0000; e.rd1 = d1; e.rd2 = d2;
        e.rd = rd; e.ctrl = pc[15:0]; e.we = we; e.mr = mr; e.sel1 = s1; e.sel2 = s2;
        return e;
    endfunction

    task automatic set_idle();
        bus.IN_VALID = 0; bus.IN_PC = '0; bus.IN_IMM = '0; bus.IN_RDATA1 = '0; bus.IN_RDATA2 = '0;
        bus.IN_RS1 = '0; bus.IN_RS2 = '0; bus.IN_RD = '0; bus.IN_USES_RS1 = 0; bus.IN_USES_RS2 = 0;
        bus.IN_WRITE_EN = 0; bus.IN_MEM_READ = 0; bus.IN_CTRL = '0;
        bus.WB_WE = 0; bus.WB_RD = '0; bus.WB_DATA = '0; bus.FWD_WE = '0; bus.FWD_RD = '0;
        bus.FLUSH = 0; bus.OUT_READY = 1;
    endtask

    task automatic clear_bypass();
        bus.WB_WE = 0; bus.WB_RD = '0; bus.WB_DATA = '0; bus.FWD_WE = '0; bus.FWD_RD = '0;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2, input logic we,
                             input logic mr, input logic [31:0] d1, input logic [31:0] d2);
        bus.IN_VALID = 1; bus.IN_PC = pc; bus.IN_IMM = pc ^ 32'hA5A5_0000; bus.IN_CTRL = pc[15:0];
        bus.IN_RS1 = rs1; bus.IN_RS2 = rs2; bus.IN_RD = rd; bus.IN_USES_RS1 = u1; bus.IN_USES_RS2 = u2;
        bus.IN_WRITE_EN = we; bus.IN_MEM_READ = mr; bus.IN_RDATA1 = d1; bus.IN_RDATA2 = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        #2;
        vectors++;
        if (obs() !== exp_t'(0)) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", obs());
        end
        vectors++;
        if (bus.STALL_CNT !== 32'd0) begin
            miscompares++; $display("FAIL reset_stall: got %0d want 0", bus.STALL_CNT);
        end
        vectors++;
        if (bus.IN_READY !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.IN_READY);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        exp_t e;
        set_instr(32'h100, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 32'h11, 32'h22);
        sbq.push_back(mk_exp(32'h100, 32'h11, 32'h22, 5'd5, 1, 1, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL lw_capture: got %h want %h", obs(), e); end
        set_instr(32'h104, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 32'h33, 32'h44);
        #1;
        vectors++;
        if (bus.IN_READY !== 1'b0) begin miscompares++; $display("FAIL loaduse_ready: got %b want 0", bus.IN_READY); end
        tick();
        vectors++;
        if ({bus.OUT_VALID, bus.OUT_WRITE_EN, bus.OUT_MEM_READ, bus.OUT_FWD_SEL1, bus.OUT_FWD_SEL2} !== 7'd0) begin
            miscompares++;
            $display("FAIL bubble_fields: got v%b we%b mr%b s%0d/%0d want all 0", bus.OUT_VALID,
                     bus.OUT_WRITE_EN, bus.OUT_MEM_READ, bus.OUT_FWD_SEL1, bus.OUT_FWD_SEL2);
        end
        vectors++;
        if (bus.STALL_CNT !== 32'd1) begin miscompares++; $display("FAIL bubble_stall: got %0d want 1", bus.STALL_CNT); end
        bus.FWD_WE = 2'b01; bus.FWD_RD = {5'd0, 5'd5};
        #1;
        vectors++;
        if (bus.IN_READY !== 1'b1) begin miscompares++; $display("FAIL after_bubble_ready: got %b want 1", bus.IN_READY); end
        sbq.push_back(mk_exp(32'h104, 32'h33, 32'h44, 5'd6, 1, 0, 2'd2, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL add_after_bubble: got %h want %h", obs(), e); end
        clear_bypass();
    endtask

    task automatic test_nearest_wins();
        exp_t e;
        set_instr(32'h108, 5'd8, 5'd9, 5'd7, 1, 1, 1, 0, 32'h1, 32'h2);
        sbq.push_back(mk_exp(32'h108, 32'h1, 32'h2, 5'd7, 1, 0, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL add_x7: got %h want %h", obs(), e); end
        set_instr(32'h10C, 5'd8, 5'd7, 5'd10, 1, 1, 1, 0, 32'h3, 32'h4);
        bus.FWD_WE = 2'b11; bus.FWD_RD = {5'd7, 5'd7};
        sbq.push_back(mk_exp(32'h10C, 32'h3, 32'h4, 5'd10, 1, 0, 2'd0, 2'd1));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL nearest_wins: got %h want %h", obs(), e); end
        clear_bypass();
    endtask

    task automatic test_wb_bypass();
        exp_t e;
        set_instr(32'h110, 5'd3, 5'd3, 5'd11, 1, 0, 1, 0, 32'h0, 32'h55);
        bus.WB_WE = 1; bus.WB_RD = 5'd3; bus.WB_DATA = 32'hDEADBEEF;
        sbq.push_back(mk_exp(32'h110, 32'hDEADBEEF, 32'h55, 5'd11, 1, 0, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL wb_bypass: got %h want %h", obs(), e); end
        clear_bypass();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bus.OUT_READY = 0;
        set_instr(32'h114, 5'd1, 5'd2, 5'd12, 1, 1, 1, 0, 32'h5, 32'h6);
        #1;
        vectors++;
        if (bus.IN_READY !== 1'b0) begin miscompares++; $display("FAIL hold_ready: got %b want 0", bus.IN_READY); end
        tick();
        vectors++;
        if (obs() !== last) begin miscompares++; $display("FAIL hold_outputs: got %h want %h", obs(), last); end
        bus.OUT_READY = 1;
        sbq.push_back(mk_exp(32'h114, 32'h5, 32'h6, 5'd12, 1, 0, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL release_capture: got %h want %h", obs(), e); end
    endtask

    task automatic test_flush();
        exp_t e;
        set_instr(32'h118, 5'd0, 5'd0, 5'd5, 0, 0, 1, 1, 32'h7, 32'h8);
        sbq.push_back(mk_exp(32'h118, 32'h7, 32'h8, 5'd5, 1, 1, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL lw_before_flush: got %h want %h", obs(), e); end
        bus.OUT_READY = 0;
        set_instr(32'h11C, 5'd5, 5'd0, 5'd13, 1, 0, 1, 0, 32'h9, 32'h9);
        #1;
        vectors++;
        if (bus.IN_READY !== 1'b0) begin miscompares++; $display("FAIL preflush_ready: got %b want 0", bus.IN_READY); end
        bus.FLUSH = 1;
        #1;
        vectors++;
        if (bus.IN_READY !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", bus.IN_READY); end
        tick();
        vectors++;
        if ({bus.OUT_VALID, bus.OUT_WRITE_EN, bus.OUT_MEM_READ, bus.OUT_FWD_SEL1, bus.OUT_FWD_SEL2} !== 7'd0) begin
            miscompares++;
            $display("FAIL flush_fields: got v%b we%b mr%b s%0d/%0d want all 0", bus.OUT_VALID,
                     bus.OUT_WRITE_EN, bus.OUT_MEM_READ, bus.OUT_FWD_SEL1, bus.OUT_FWD_SEL2);
        end
        vectors++;
        if (bus.STALL_CNT !== 32'd1) begin miscompares++; $display("FAIL flush_stall: got %0d want 1", bus.STALL_CNT); end
        bus.FLUSH = 0; bus.OUT_READY = 1;
    endtask

    task automatic test_x0();
        exp_t e;
        set_instr(32'h120, 5'd0, 5'd0, 5'd14, 1, 1, 1, 0, 32'hA, 32'hB);
        bus.FWD_WE = 2'b01; bus.FWD_RD = {5'd0, 5'd0};
        bus.WB_WE = 1; bus.WB_RD = 5'd0; bus.WB_DATA = 32'hFFFF_FFFF;
        sbq.push_back(mk_exp(32'h120, 32'hA, 32'hB, 5'd14, 1, 0, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front(); last = e;
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL x0_select: got %h want %h", obs(), e); end
        clear_bypass();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        set_instr(32'h200, 5'd0, 5'd0, 5'd12, 0, 0, 1, 0, 32'h1, 32'h2);
        sbq.push_back(mk_exp(32'h200, 32'h1, 32'h2, 5'd12, 1, 0, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front();
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL b2b_a: got %h want %h", obs(), e); end
        set_instr(32'h204, 5'd12, 5'd13, 5'd14, 1, 1, 0, 0, 32'h3, 32'h4);
        bus.FWD_WE = 2'b10; bus.FWD_RD = {5'd13, 5'd0};
        sbq.push_back(mk_exp(32'h204, 32'h3, 32'h4, 5'd14, 0, 0, 2'd1, 2'd3));
        tick();
        e = sbq.pop_front();
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL b2b_b: got %h want %h", obs(), e); end
        set_instr(32'h208, 5'd13, 5'd14, 5'd15, 1, 1, 1, 0, 32'h5, 32'h6);
        bus.FWD_WE = 2'b11; bus.FWD_RD = {5'd13, 5'd13};
        sbq.push_back(mk_exp(32'h208, 32'h5, 32'h6, 5'd15, 1, 0, 2'd2, 2'd0));
        tick();
        e = sbq.pop_front();
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL b2b_c: got %h want %h", obs(), e); end
        set_idle();
        tick();
        vectors++;
        if (bus.OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", bus.OUT_VALID); end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        set_instr(32'h300, 5'd0, 5'd0, 5'd5, 0, 0, 1, 1, 32'h0, 32'h0);
        sbq.push_back(mk_exp(32'h300, 32'h0, 32'h0, 5'd5, 1, 1, 2'd0, 2'd0));
        tick();
        e = sbq.pop_front();
        vectors++;
        if (obs() !== e) begin miscompares++; $display("FAIL lw_before_reset: got %h want %h", obs(), e); end
        set_instr(32'h304, 5'd5, 5'd0, 5'd6, 1, 0, 1, 0, 32'h0, 32'h0);
        #1;
        vectors++;
        if (bus.IN_READY !== 1'b0) begin miscompares++; $display("FAIL midstall_ready: got %b want 0", bus.IN_READY); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== exp_t'(0)) begin miscompares++; $display("FAIL async_reset: got %h want 0", obs()); end
        vectors++;
        if (bus.STALL_CNT !== 32'd0) begin miscompares++; $display("FAIL async_reset_stall: got %0d want 0", bus.STALL_CNT); end
        bus.IN_VALID = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({bus.OUT_VALID, bus.IN_READY, bus.STALL_CNT} !== {1'b0, 1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL post_reset_edge: got v%b rdy%b stall%0d want v0 rdy1 stall0",
                     bus.OUT_VALID, bus.IN_READY, bus.STALL_CNT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_nearest_wins();
        test_wb_bypass();
        test_backpressure();
        test_flush();
        test_x0();
        test_back_to_back();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
